// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the fixed-ratio clock divider.
package clk_div_pkg;

  localparam int unsigned CLK_DIV_10M = 10;

  // Counter width for a ratio; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/div_counter.sv
// Wrap-around 0..DIV-1 counter with async active-high clear and half/wrap decode strobes.
module div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV = CLK_DIV_10M,
  parameter int unsigned W   = cnt_width(DIV)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt,
  output logic         half_hit,
  output logic         wrap_hit
);

  // Even ratios flip at DIV/2-1; odd ratios flip one count later so the posedge
  // phase is the shorter one and the negedge register stretches it.
  localparam int unsigned HALF = (DIV % 2 == 0) ? DIV / 2 - 1 : (DIV - 1) / 2;
  localparam logic [W-1:0] HALF_V = W'(HALF);
  localparam logic [W-1:0] WRAP_V = W'(DIV - 1);

  always_comb begin
    half_hit = (cnt == HALF_V);
    wrap_hit = (cnt == WRAP_V);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap_hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/clk_divider.sv
// Fixed-ratio 50%-duty clock divider; odd ratios use a posedge/negedge register pair.
module clk_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV = CLK_DIV_10M
) (
  input  logic clk,
  input  logic rst_n,    // active-high asynchronous reset despite the name
  output logic clk_10m
);

  localparam int unsigned W = cnt_width(DIV);

  if (DIV < 2) begin : g_div_check
    $fatal(1, "clk_divider: DIV must be >= 2");
  end

  logic [W-1:0] cnt;
  logic         half_hit;
  logic         wrap_hit;

  div_counter #(
    .DIV(DIV),
    .W  (W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst_n),
    .cnt     (cnt),
    .half_hit(half_hit),
    .wrap_hit(wrap_hit)
  );

  if (DIV % 2 == 0) begin : g_even
    logic q_p;

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        q_p <= 1'b0;
      end else if (half_hit || wrap_hit) begin
        q_p <= ~q_p;
      end
    end

    assign clk_10m = q_p;
  end else begin : g_odd
    logic q_p;
    logic q_n;

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        q_p <= 1'b0;
      end else if (half_hit || wrap_hit) begin
        q_p <= ~q_p;
      end
    end

    // Half-cycle delayed copy extends the high phase to DIV/2 cycles.
    always_ff @(negedge clk or posedge rst_n) begin
      if (rst_n) begin
        q_n <= 1'b0;
      end else begin
        q_n <= q_p;
      end
    end

    assign clk_10m = q_p | q_n;
  end

  cnt_in_range: assert property (@(posedge clk) disable iff (rst_n) 32'(cnt) < DIV);

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider at DIV = 10, 5 and 2 sharing one clock and reset.
module tb_clk_divider;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic out10;
  logic out5;
  logic out2;

  int vectors     = 0;
  int miscompares = 0;

  int     divs [3] = '{10, 5, 2};
  int     rise_cnt [3];
  int     fall_cnt [3];
  int     exp_rise [3];
  int     exp_fall [3];
  bit     prev_exp [3];
  longint last_rise [3];
  longint last_fall [3];
  longint hi_w [3];
  longint lo_w [3];
  int     half_t   = 0;
  bit     in_reset = 1'b1;

  always #5 clk = ~clk;

  clk_divider #(.DIV(10)) u_div10 (.clk(clk), .rst_n(rst_n), .clk_10m(out10));
  clk_divider #(.DIV(5))  u_div5  (.clk(clk), .rst_n(rst_n), .clk_10m(out5));
  clk_divider #(.DIV(2))  u_div2  (.clk(clk), .rst_n(rst_n), .clk_10m(out2));

  task automatic edge_seen(input int i, input logic v);
    if (v === 1'b1) begin
      rise_cnt[i]++;
      if (last_fall[i] >= 0) lo_w[i] = longint'($time) - last_fall[i];
      last_rise[i] = longint'($time);
    end else begin
      fall_cnt[i]++;
      if (last_rise[i] >= 0) hi_w[i] = longint'($time) - last_rise[i];
      last_fall[i] = longint'($time);
    end
  endtask

  always @(out10) edge_seen(0, out10);
  always @(out5)  edge_seen(1, out5);
  always @(out2)  edge_seen(2, out2);

  // Output level at half-cycle index t since release (posedge k is t = 2k, the
  // following negedge 2k+1): low until the first rise at 2*ceil(DIV/2), then
  // high for DIV half-cycles out of every 2*DIV.
  function automatic bit model(input int div, input int t, input bit rst);
    int r;
    if (rst) return 1'b0;
    r = 2 * ((div + 1) / 2);
    if (t < r) return 1'b0;
    return ((t - r) % (2 * div)) < div;
  endfunction

  function automatic logic dut_out(input int i);
    case (i)
      0:       return out10;
      1:       return out5;
      default: return out2;
    endcase
  endfunction

  task automatic clear_mon();
    for (int i = 0; i < 3; i++) begin
      rise_cnt[i]  = 0;
      fall_cnt[i]  = 0;
      exp_rise[i]  = 0;
      exp_fall[i]  = 0;
      prev_exp[i]  = 1'b0;
      last_rise[i] = -1;
      last_fall[i] = -1;
      hi_w[i]      = 0;
      lo_w[i]      = 0;
    end
  endtask

  task automatic sample_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      bit   e;
      logic o;
      e = model(divs[i], half_t, in_reset);
      o = dut_out(i);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s div=%0d t_half=%0d: clk_10m=%b expected %b", tag, divs[i], half_t, o, e);
      end
      if (e != prev_exp[i]) begin
        if (e) exp_rise[i]++;
        else   exp_fall[i]++;
        prev_exp[i] = e;
      end
    end
  endtask

  task automatic run_cycles(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      #1;
      half_t++;
      sample_all(tag);
      @(negedge clk);
      #1;
      half_t++;
      sample_all(tag);
    end
  endtask

  task automatic assert_reset(input string tag);
    rst_n    = 1'b1;
    in_reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (dut_out(i) !== 1'b0) begin
        miscompares++;
        $display("FAIL %s div=%0d: clk_10m=%b after reset expected 0", tag, divs[i], dut_out(i));
      end
    end
    clear_mon();
  endtask

  task automatic release_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n    = 1'b0;
    in_reset = 1'b0;
    half_t   = 1;
  endtask

  task automatic check_edges(input string tag);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rise_cnt[i] !== exp_rise[i]) begin
        miscompares++;
        $display("FAIL %s_rises div=%0d: saw %0d expected %0d", tag, divs[i], rise_cnt[i],
                 exp_rise[i]);
      end
      vectors++;
      if (fall_cnt[i] !== exp_fall[i]) begin
        miscompares++;
        $display("FAIL %s_falls div=%0d: saw %0d expected %0d", tag, divs[i], fall_cnt[i],
                 exp_fall[i]);
      end
    end
  endtask

  task automatic check_duty(input string tag);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (hi_w[i] != longint'(5 * divs[i]) || lo_w[i] != longint'(5 * divs[i])) begin
        miscompares++;
        $display("FAIL %s div=%0d: high %0d low %0d expected %0d each", tag, divs[i], hi_w[i],
                 lo_w[i], 5 * divs[i]);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    assert_reset("reset_assert");
    repeat (9) begin
      run_cycles(1, "reset_hold");
      vectors++;
      if (u_div10.u_cnt.cnt !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_hold_cnt: cnt=%0d expected 0", u_div10.u_cnt.cnt);
      end
    end
    check_edges("reset_hold");
  endtask

  task automatic test_release();
    release_reset();
    run_cycles(4, "release");
    vectors++;
    if (out10 !== 1'b0) begin
      miscompares++;
      $display("FAIL release_before_rise: clk_10m=%b expected 0 after edge 4", out10);
    end
    run_cycles(1, "release");
    vectors++;
    if (out10 !== 1'b1) begin
      miscompares++;
      $display("FAIL release_first_rise: clk_10m=%b expected 1 after edge 5", out10);
    end
    run_cycles(210, "steady");
    check_edges("steady");
    check_duty("steady_duty");
  endtask

  task automatic test_frequency();
    int exp_rises [3] = '{100, 200, 500};
    assert_reset("freq_reset");
    run_cycles($urandom_range(1, 4), "freq_hold");
    release_reset();
    run_cycles(1000, "freq");
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rise_cnt[i] != exp_rises[i]) begin
        miscompares++;
        $display("FAIL freq_10us div=%0d: %0d rises expected %0d", divs[i], rise_cnt[i],
                 exp_rises[i]);
      end
    end
    check_edges("freq");
    check_duty("freq_duty");
  endtask

  task automatic test_async_reset();
    repeat (6) begin
      int guard;
      assert_reset("async_pre");
      run_cycles($urandom_range(1, 3), "async_hold");
      release_reset();
      run_cycles($urandom_range(3, 30), "async_run");
      guard = 0;
      while (!prev_exp[0] && guard < 20) begin
        run_cycles(1, "async_seek");
        guard++;
      end
      vectors++;
      if (out10 !== 1'b1) begin
        miscompares++;
        $display("FAIL async_pre_high: clk_10m=%b expected 1 before reset", out10);
      end
      #($urandom_range(0, 2));
      assert_reset("async_mid_high");
      run_cycles($urandom_range(1, 5), "async_in_reset");
      release_reset();
      run_cycles(12, "async_rerelease");
      check_edges("async");
    end
  endtask

  task automatic test_odd_duty();
    assert_reset("odd_reset");
    release_reset();
    run_cycles(60, "odd");
    vectors++;
    if (hi_w[1] != 25 || lo_w[1] != 25) begin
      miscompares++;
      $display("FAIL odd_div5_duty: high %0d low %0d expected 25/25", hi_w[1], lo_w[1]);
    end
    vectors++;
    if (hi_w[2] != 10 || lo_w[2] != 10) begin
      miscompares++;
      $display("FAIL even_div2_duty: high %0d low %0d expected 10/10", hi_w[2], lo_w[2]);
    end
    check_edges("odd");
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_release();
    test_frequency();
    test_async_reset();
    test_odd_duty();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_divider.md
# clk_divider

Fixed-ratio clock divider that derives a 50%-duty, 10 MHz clock (`clk_10m`) from the 100 MHz system clock. It is a leaf block at the clock-generation level. Its output feeds downstream logic as a slow clock or clock-enable source. The ratio is a parameter, and both even and odd ratios produce an exact 50% duty cycle.

## Interface
- `DIV`, default 10: integer division ratio. Must be ≥ 2; elaboration fails otherwise.
- `clk` input 1: system clock, 100 MHz (10 ns period).
- `rst_n` input 1: asynchronous reset, **active-high**. The `_n` name is retained for codebase compatibility; asserting it to 1 resets the block.
- `clk_10m` output 1: divided clock, frequency clk/DIV, 50% duty.

## Operation
- Counter `cnt`, width $clog2(DIV), increments on every `clk` rising edge.
  - Wraps DIV-1 → 0.
  - Never takes values ≥ DIV.
- Even DIV, single posedge register `q_p`:
  - `q_p` toggles on the rising edge where `cnt == DIV/2-1`.
  - `q_p` also toggles on the rising edge where `cnt == DIV-1`.
  - `clk_10m = q_p`, i.e. registered and glitch-free.
- Odd DIV, two registers:
  - `q_p` (posedge) toggles where `cnt == (DIV-1)/2` and where `cnt == DIV-1`. This gives (DIV-1)/2 cycles high and (DIV+1)/2 cycles low.
  - `q_n` captures `q_p` on the `clk` falling edge.
  - `clk_10m = q_p | q_n`, which is high for DIV/2 cycles (half-cycle resolution).
- Even/odd selection is made at elaboration via generate. Only one branch is built.
- Reset, asynchronous (`rst_n` = 1):
  - `cnt` = 0, `q_p` = 0, `q_n` = 0, `clk_10m` = 0, immediately and independent of `clk`.
  - Holds while asserted.
  - Reset applied mid-period truncates the current output phase. There is no completion of the period.

## Timing
- DIV = 10, first rising edge after reset release (cnt 0 → 1) is edge 1:
  - `clk_10m` rises after edge 5 (cnt 4 → 5).
  - It falls after edge 10 (cnt 9 → 0).
  - It rises again after edge 15, and so on.
- Steady state: 50 ns high, 50 ns low, period 100 ns.
- Odd DIV (e.g. 5):
  - Rise follows the `q_p` posedge.
  - Fall follows the `q_n` negedge, half a cycle after `q_p` falls.
  - High time = 2.5 cycles.
- Output changes only as a clock-to-Q delay from `clk` edges. There are no combinational paths from `rst_n` other than the asynchronous clear.
- No phase alignment to any other clock is guaranteed beyond the cycle positions above.

## Structure
- Shared package `clk_div_pkg`:
  - Default ratio constant `CLK_DIV_10M` = 10.
  - Function computing counter width: $clog2 with minimum 1.
- Natural sub-module `div_counter`: parameterized wrap-around counter with async active-high clear. It exposes `cnt` plus two decode strobes, `half_hit` and `wrap_hit`.
- The top `clk_divider` instantiates `div_counter`. It holds the generate branches for the even path (toggle register) and the odd path (posedge/negedge pair and OR).
- Add an elaboration-time assertion for DIV < 2.

## Test plan
- **Reset hold:** `rst_n` = 1 for 100 ns with `clk` running → `clk_10m` = 0 and `cnt` = 0 throughout.
- **Release, DIV = 10:** `rst_n` → 0 at t = 100 ns → first `clk_10m` rise 5 `clk` edges later. Then strict 50 ns high / 50 ns low for ≥ 20 periods.
- **Frequency check:** count `clk_10m` rising edges over 10 µs → exactly 100 (±1 for the boundary).
- **Async reset mid-high:** assert `rst_n` at an arbitrary non-edge time while `clk_10m` = 1 → `clk_10m` = 0 within the same timestep.
  - On release, the rise occurs 5 edges later, identical to the initial sequence.
- **Odd ratio, DIV = 5:** measure high time 25 ns and low time 25 ns, period 50 ns. Confirm there are no glitches on `clk_10m` at any `clk` edge.
- **Even ratio, DIV = 2:** `clk_10m` toggles every rising edge → period 20 ns, 50% duty, first rise after edge 1.
